// File: rtl/num_ctrl.sv
// num_ctrl: enter-key debouncer, 8-bit operand capture, sequential
// shift-add-3 binary-to-BCD converter and seven-segment digit scanner.
// Optional build macro NUM_HEX_EN: adds the two hex digits of the captured
// operand to the scan (digits 3 and 4); without it only the BCD digits scan.

module num_ctrl #(
  parameter int DBNC_CYCLES = 1,
  parameter int SCAN_DIV    = 4
) (
  input  logic        clk,
  input  logic        KEY0,
  input  logic        KEY1,
  input  logic [7:0]  switches,
  output logic [7:0]  value,
  output logic [11:0] bcd,
  output logic        busy,
  output logic        done,
  output logic [4:0]  digit_sel,
  output logic [3:0]  digit_val
);

  localparam int DW = (DBNC_CYCLES > 1) ? $clog2(DBNC_CYCLES + 1) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

`ifdef NUM_HEX_EN
  localparam logic [2:0] LAST_IDX = 3'd4;
`else
  localparam logic [2:0] LAST_IDX = 3'd2;
`endif

  typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;

  logic          sync_a;
  logic          sync_b;
  logic          stable;
  logic [DW-1:0] dbnc_cnt;
  logic          press;

  state_t        state;
  logic [19:0]   shift_reg;
  logic [19:0]   adj;
  logic [19:0]   shifted;
  logic [2:0]    iter;

  logic [SW-1:0] scan_div;
  logic [2:0]    scan_idx;
  logic [2:0]    next_idx;
  logic [3:0]    next_nib;

  // Two-flop synchronizer for the raw key; idles high like the released key
  always_ff @(posedge clk or negedge KEY0) begin
    if (!KEY0) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
    end else begin
      sync_a <= KEY1;
      sync_b <= sync_a;
    end
  end

  // Debounce: adopt a new level once it has persisted, pulse press on 1->0
  always_ff @(posedge clk or negedge KEY0) begin
    if (!KEY0) begin
      stable   <= 1'b1;
      dbnc_cnt <= '0;
      press    <= 1'b0;
    end else if (sync_b != stable) begin
      if (dbnc_cnt == DW'(DBNC_CYCLES - 1)) begin
        stable   <= sync_b;
        dbnc_cnt <= '0;
        press    <= ~sync_b;
      end else begin
        dbnc_cnt <= dbnc_cnt + DW'(1);
        press    <= 1'b0;
      end
    end else begin
      dbnc_cnt <= '0;
      press    <= 1'b0;
    end
  end

  // One double-dabble step: correct each BCD nibble >= 5, then shift left
  always_comb begin
    adj = shift_reg;
    if (shift_reg[19:16] >= 4'd5) adj[19:16] = shift_reg[19:16] + 4'd3;
    if (shift_reg[15:12] >= 4'd5) adj[15:12] = shift_reg[15:12] + 4'd3;
    if (shift_reg[11:8]  >= 4'd5) adj[11:8]  = shift_reg[11:8]  + 4'd3;
    shifted = adj << 1;
  end

  // Control FSM: capture on press, run eight conversion steps, publish result
  always_ff @(posedge clk or negedge KEY0) begin
    if (!KEY0) begin
      state     <= IDLE;
      value     <= '0;
      bcd       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      shift_reg <= '0;
      iter      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, SHOW: begin
          if (press) begin
            value     <= switches;
            shift_reg <= {12'h000, switches};
            iter      <= '0;
            busy      <= 1'b1;
            state     <= CONV;
          end
        end
        CONV: begin
          shift_reg <= shifted;
          iter      <= iter + 3'd1;
          if (iter == 3'd7) begin
            bcd   <= shifted[19:8];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= SHOW;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Digit the scanner moves to next and the nibble it will display there
  always_comb begin
    next_idx = (scan_idx == LAST_IDX) ? 3'd0 : scan_idx + 3'd1;
    next_nib = 4'h0;
    case (next_idx)
      3'd0: next_nib = bcd[3:0];
      3'd1: next_nib = bcd[7:4];
      3'd2: next_nib = bcd[11:8];
`ifdef NUM_HEX_EN
      3'd3: next_nib = value[3:0];
      3'd4: next_nib = value[7:4];
`endif
      default: next_nib = 4'h0;
    endcase
  end

  // Free-running scanner: hold each digit SCAN_DIV cycles, then advance
  always_ff @(posedge clk or negedge KEY0) begin
    if (!KEY0) begin
      scan_div  <= '0;
      scan_idx  <= '0;
      digit_sel <= 5'b11110;
      digit_val <= 4'h0;
    end else if (scan_div == SW'(SCAN_DIV - 1)) begin
      scan_div  <= '0;
      scan_idx  <= next_idx;
`ifdef NUM_HEX_EN
      digit_sel <= ~(5'b00001 << next_idx);
`else
      digit_sel <= {2'b11, ~(3'b001 << next_idx)};
`endif
      digit_val <= next_nib;
    end else begin
      scan_div <= scan_div + SW'(1);
    end
  end

endmodule

// File: tb/tb_num_ctrl.sv
// Testbench for num_ctrl: a fast-debounce instance drives the table of
// conversions and the multi-cycle key sequences, a slow-debounce instance
// covers glitch rejection. Works in both NUM_HEX_EN builds.

module tb_num_ctrl;

`ifdef NUM_HEX_EN
  localparam int ND = 5;
`else
  localparam int ND = 3;
`endif

  logic        clk = 1'b0;
  logic        KEY0;
  logic        key_fast;
  logic        key_slow;
  logic [7:0]  switches;

  logic [7:0]  f_value, s_value;
  logic [11:0] f_bcd, s_bcd;
  logic        f_busy, s_busy, f_done, s_done;
  logic [4:0]  f_sel, s_sel;
  logic [3:0]  f_val, s_val;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0]  sw;
    logic [11:0] bcd;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  num_ctrl #(.DBNC_CYCLES(1), .SCAN_DIV(4)) dut_fast (
    .clk(clk), .KEY0(KEY0), .KEY1(key_fast), .switches(switches),
    .value(f_value), .bcd(f_bcd), .busy(f_busy), .done(f_done),
    .digit_sel(f_sel), .digit_val(f_val)
  );

  num_ctrl #(.DBNC_CYCLES(4), .SCAN_DIV(4)) dut_slow (
    .clk(clk), .KEY0(KEY0), .KEY1(key_slow), .switches(switches),
    .value(s_value), .bcd(s_bcd), .busy(s_busy), .done(s_done),
    .digit_sel(s_sel), .digit_val(s_val)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Press the key (low for 'hold' edges) and watch 40 cycles of response
  task automatic applyStimulus(input bit slow, input logic [7:0] sw, input int hold,
                               output int lat, output int busy_n, output int done_n);
    switches = sw;
    if (slow) key_slow = 1'b0; else key_fast = 1'b0;
    lat = 0; busy_n = 0; done_n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (slow ? s_busy : f_busy) busy_n++;
      if (slow ? s_done : f_done) begin
        done_n++;
        if (lat == 0) lat = i;
      end
      if (i == hold) begin
        if (slow) key_slow = 1'b1; else key_fast = 1'b1;
      end
    end
  endtask

  initial begin
    int lat, bn, dn, idx, prev_idx, max_idx, first_done, seen;
    logic [4:0] exp_sel;
    logic [3:0] exp_nib [5];

    exp_nib[0] = 4'h6; exp_nib[1] = 4'h5; exp_nib[2] = 4'h1;
    exp_nib[3] = 4'hC; exp_nib[4] = 4'h9;

    vecs[0] = '{8'h20, 12'h032};
    vecs[1] = '{8'hff, 12'h255};
    vecs[2] = '{8'h80, 12'h128};
    vecs[3] = '{8'h00, 12'h000};
    vecs[4] = '{8'h01, 12'h001};
    vecs[5] = '{8'h63, 12'h099};
    vecs[6] = '{8'h64, 12'h100};
    vecs[7] = '{8'hc8, 12'h200};
    vecs[8] = '{8'h9c, 12'h156};

    KEY0 = 1'b0; key_fast = 1'b1; key_slow = 1'b1; switches = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("rst_value", 32'(f_value), 'h0);
    checkOutput("rst_bcd", 32'(f_bcd), 'h0);
    checkOutput("rst_busy", 32'(f_busy), 'h0);
    checkOutput("rst_done", 32'(f_done), 'h0);
    checkOutput("rst_sel", 32'(f_sel), 'h1e);
    checkOutput("rst_val", 32'(f_val), 'h0);

    // Scanner after reset release: one step every 4 cycles
    KEY0 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_sel = ~(5'b00001 << ((k / 4) % ND));
      checkOutput("scan_step", 32'(f_sel), 32'(exp_sel));
    end

    // Table of conversions: press-to-done is 2 sync + 1 debounce + 9
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, vecs[i].sw, 1, lat, bn, dn);
      checkOutput("conv_bcd", 32'(f_bcd), 32'(vecs[i].bcd));
      checkOutput("conv_value", 32'(f_value), 32'(vecs[i].sw));
      checkOutput("conv_latency", 32'(lat), 12);
      checkOutput("conv_busy_cycles", 32'(bn), 8);
      checkOutput("conv_done_pulses", 32'(dn), 1);
    end

    // Digit scan of the last capture (8'h9c -> 156)
    prev_idx = -1; max_idx = 0;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      idx = -1;
      for (int j = 0; j < 5; j++) if (f_sel == ~(5'b00001 << j)) idx = j;
      checkOutput("scan_onehot", 32'(idx >= 0 && idx < ND), 1);
      if (idx >= 0 && idx < 5) begin
        checkOutput("scan_digit_val", 32'(f_val), 32'(exp_nib[idx]));
        if (idx > max_idx) max_idx = idx;
        if (prev_idx >= 0 && idx != prev_idx)
          checkOutput("scan_order", 32'(idx), 32'((prev_idx + 1) % ND));
        prev_idx = idx;
      end
`ifndef NUM_HEX_EN
      checkOutput("scan_hex_off", 32'(f_sel[4:3]), 'h3);
`endif
    end
    checkOutput("scan_max_idx", 32'(max_idx), 32'(ND - 1));

    // Second press 3 cycles after the first is dropped
    switches = 8'h1f; key_fast = 1'b0; dn = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (f_done) dn++;
      if (i == 1) key_fast = 1'b1;
      if (i == 3) key_fast = 1'b0;
      if (i == 4) begin key_fast = 1'b1; switches = 8'h11; end
    end
    checkOutput("drop_done_pulses", 32'(dn), 1);
    checkOutput("drop_bcd", 32'(f_bcd), 'h031);
    checkOutput("drop_value", 32'(f_value), 'h1f);

    // Press coinciding with the done cycle is accepted
    switches = 8'h3f; key_fast = 1'b0; dn = 0; first_done = 0; lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (f_done) begin
        dn++;
        if (first_done == 0) first_done = i; else if (lat == 0) lat = i;
      end
      if (i == 12) checkOutput("coin_busy_low", 32'(f_busy), 0);
      if (i == 13) checkOutput("coin_busy_again", 32'(f_busy), 1);
      if (i == 1) key_fast = 1'b1;
      if (i == 4) switches = 8'h2a;
      if (i == 9) key_fast = 1'b0;
      if (i == 10) key_fast = 1'b1;
    end
    checkOutput("coin_done_pulses", 32'(dn), 2);
    checkOutput("coin_first_done", 32'(first_done), 12);
    checkOutput("coin_second_done", 32'(lat), 21);
    checkOutput("coin_bcd", 32'(f_bcd), 'h042);
    checkOutput("coin_value", 32'(f_value), 'h2a);

    // Slow debounce: a 2-cycle glitch is ignored, a held press converts
    key_slow = 1'b0; bn = 0; dn = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (s_busy) bn++;
      if (s_done) dn++;
      if (i == 2) key_slow = 1'b1;
    end
    checkOutput("glitch_busy", 32'(bn), 0);
    checkOutput("glitch_done", 32'(dn), 0);
    checkOutput("glitch_value", 32'(s_value), 'h0);
    applyStimulus(1'b1, 8'h80, 6, lat, bn, dn);
    checkOutput("slow_latency", 32'(lat), 15);
    checkOutput("slow_busy_cycles", 32'(bn), 8);
    checkOutput("slow_done_pulses", 32'(dn), 1);
    checkOutput("slow_bcd", 32'(s_bcd), 'h128);

    // Reset during conversion aborts immediately
    switches = 8'hff; key_fast = 1'b0; seen = 0;
    @(negedge clk);
    key_fast = 1'b1;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      @(negedge clk);
      if (f_busy) seen = 1;
    end
    checkOutput("abort_busy_seen", 32'(seen), 1);
    repeat (3) @(negedge clk);
    KEY0 = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(f_busy), 0);
    checkOutput("abort_bcd", 32'(f_bcd), 'h0);
    checkOutput("abort_value", 32'(f_value), 'h0);
    checkOutput("abort_sel", 32'(f_sel), 'h1e);
    @(negedge clk);
    @(negedge clk);
    KEY0 = 1'b1;
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (f_done) dn++;
    end
    checkOutput("abort_no_done", 32'(dn), 0);
    checkOutput("abort_bcd_after", 32'(f_bcd), 'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
